dtr_pulse_gen: RTL
==================

# dtr_pulse_gen

Drives a DTR-style reset-request line: on a request strobe, pulls `dtr_out` low for a fixed number of cycles, then holds it high for a mandatory hold-off before it accepts another pulse. It is the transmitting end of the DTR reset protocol. The falling edge it produces is what the FPGA-side DTR reset detector of a target board acts on. It sits in the IO group and is used when one FPGC board resets another, and for loopback testing of the detector.

## Interface
Parameters:
- `LOW_CYCLES`, 16: cycles `dtr_out` is held low per pulse; legal range ≥1.
- `HOLDOFF_CYCLES`, 16: cycles `dtr_out` is held high after a pulse before the block is idle again; legal range ≥1.
- `CNT_W`, `$clog2(max(LOW_CYCLES,HOLDOFF_CYCLES)+1)`: counter width; derived, do not override.

Ports:
- `clk`  in  1: sole clock; all logic on rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `req`  in  1: request strobe; every cycle it is high counts as one request.
- `dtr_out`  out  1: DTR line; idles high; low means a pulse is in progress.
- `ack`  out  1: one-cycle pulse in the first cycle `dtr_out` is low for a pulse.
- `busy`  out  1: high whenever state ≠ IDLE or a request is pending.
- `done`  out  1: one-cycle pulse in the cycle after the last hold-off cycle.
- `dropped`  out  1: sticky; set when a request is lost; cleared only by reset.

## Operation
- All outputs are registered.
- States:
  - IDLE: `dtr_out`=1.
  - LOW: `dtr_out`=0.
  - HOLD: `dtr_out`=1.
- Down-counter `cnt` [CNT_W-1:0]; `pending` is a 1-bit single-entry request buffer.
- IDLE & `req` → LOW:
  - `cnt` ← LOW_CYCLES-1.
  - `ack` ← 1.
- LOW: `cnt` decrements each cycle. When `cnt`==0 → HOLD, `cnt` ← HOLDOFF_CYCLES-1.
- HOLD: `cnt` decrements each cycle. When `cnt`==0:
  - `done` ← 1.
  - If `pending` or `req` → LOW, `cnt` ← LOW_CYCLES-1, `ack` ← 1, `pending` ← 0.
  - Otherwise → IDLE.
- `req` while in LOW or HOLD (excluding the final HOLD cycle), with `pending`=0: `pending` ← 1.
- `req` while `pending`=1 and the block is not starting a pulse that cycle: request is dropped, `dropped` ← 1.
- `req` in the final HOLD cycle with `pending`=1: `pending` is consumed by the new pulse and the new `req` becomes pending; nothing is dropped.
- The counter never wraps. Decrement happens only when `cnt`≠0 within LOW/HOLD.

## Timing
- Reset values:
  - state=IDLE, `dtr_out`=1.
  - `ack`, `done`, `busy`, `dropped` = 0.
  - `cnt`=0, `pending`=0.
- Reset mid-pulse takes effect on the next edge: `dtr_out` returns to 1 immediately and the hold-off is not enforced.
- Latency: `req` high in cycle t (IDLE) → `dtr_out`=0 and `ack`=1 in cycle t+1.
- `dtr_out` is low for exactly LOW_CYCLES cycles, t+1 … t+LOW_CYCLES.
- `dtr_out` is high for HOLDOFF_CYCLES cycles.
- `done`=1 in cycle t+LOW_CYCLES+HOLDOFF_CYCLES+1.
- Back-to-back pulses (pending or `req` at HOLD end): the next low phase starts in the same cycle `done` is high. Minimum high gap between pulses is therefore exactly HOLDOFF_CYCLES.
- `busy` rises in the same cycle as `ack`/`pending`. It falls in the cycle after `done` if there is no further pulse.

## Structure
- Shared package `dtr_pkg`:
  - state encoding: IDLE=2'd0, LOW=2'd1, HOLD=2'd2.
  - default `LOW_CYCLES`/`HOLDOFF_CYCLES` constants.
  - the detector uses the same package for its pulse length.
- Unused encoding 2'd3 → IDLE.
- One natural sub-module: `dtr_cycle_counter`, a loadable down-counter with a `zero` flag and a saturating decrement.
- The FSM and `pending`/`dropped` logic stay in the top module.

## Test plan
All scenarios use LOW_CYCLES=4, HOLDOFF_CYCLES=3 unless stated.
- Single `req` at cycle 10:
  - `ack` and `dtr_out`=0 at 11.
  - `dtr_out`=0 through 14, 1 at 15–17.
  - `done` at 18; `busy` 0 from 19.
- `req` at 10 and at 13 (during LOW):
  - second `ack` at 18, same cycle as `done`.
  - exactly 3 high cycles between pulses; `dropped`=0.
- `req` at 10, 12 and 13:
  - one pulse is pending, the third request is dropped.
  - `dropped`=1 from 14 and stays 1.
  - exactly two pulses are produced.
- `req` in the final HOLD cycle (17) with `pending`=0:
  - new pulse starts at 18; `done`=1 and `ack`=1 at 18.
- `reset_n`=0 at cycle 12 (mid-LOW):
  - at 13, `dtr_out`=1 and all flags 0.
  - `req` at 14 → `ack` at 15.
- Loopback with the DTR reset detector on `dtr_out`:
  - each `ack` yields exactly one reset pulse from the detector.
  - with LOW_CYCLES=1 the detector still fires once.

Source files
------------

// File: rtl/dtr_pkg.sv
// Shared definitions for the DTR reset-request protocol: state encoding,
// default pulse timing and the counter-width helper used by generator and detector.
package dtr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HOLD = 2'd2,
    ST_RSVD = 2'd3
  } dtr_state_t;

  localparam int DTR_LOW_CYCLES_DEF     = 16;
  localparam int DTR_HOLDOFF_CYCLES_DEF = 16;

  // Width needed to hold the larger of the two phase lengths.
  function automatic int dtr_cnt_width(input int low_cycles, input int hold_cycles);
    int longest;
    longest = (low_cycles > hold_cycles) ? low_cycles : hold_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/dtr_cycle_counter.sv
// Loadable down-counter for the DTR phase timers; decrement saturates at zero
// so a late decrement request can never wrap the count.
module dtr_cycle_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dtr_pulse_gen.sv
// DTR reset-request transmitter: each accepted request drives dtr_out low for
// LOW_CYCLES, then enforces HOLDOFF_CYCLES of high before the next pulse.
module dtr_pulse_gen
  import dtr_pkg::*;
#(
  parameter int LOW_CYCLES     = DTR_LOW_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES = DTR_HOLDOFF_CYCLES_DEF,
  parameter int CNT_W          = dtr_cnt_width(LOW_CYCLES, HOLDOFF_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  output logic dtr_out,
  output logic ack,
  output logic busy,
  output logic done,
  output logic dropped
);

  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  dtr_state_t       r_state;
  dtr_state_t       w_state_next;
  logic             r_pending;
  logic             w_pending_next;
  logic             r_dropped;
  logic             w_dropped_next;
  logic             r_dtr_out;
  logic             r_ack;
  logic             r_done;
  logic             r_busy;
  logic             w_ack_next;
  logic             w_done_next;
  logic             w_busy_next;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_dec;
  logic             w_cnt_zero;

  dtr_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_dropped_next = r_dropped;
    w_ack_next     = 1'b0;
    w_done_next    = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = LOW_LOAD;
    w_cnt_dec      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_state_next   = ST_LOW;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = LOW_LOAD;
          w_ack_next     = 1'b1;
        end
      end

      ST_LOW: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_zero) begin
          w_state_next   = ST_HOLD;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = HOLD_LOAD;
        end
        if (req) begin
          if (r_pending) w_dropped_next = 1'b1;
          else           w_pending_next = 1'b1;
        end
      end

      ST_HOLD: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_zero) begin
          w_done_next = 1'b1;
          if (r_pending || req) begin
            // A buffered request launches now; a fresh req alongside it takes its slot.
            w_state_next   = ST_LOW;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = LOW_LOAD;
            w_ack_next     = 1'b1;
            w_pending_next = r_pending && req;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (req) begin
          if (r_pending) w_dropped_next = 1'b1;
          else           w_pending_next = 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // The done cycle still counts as busy so busy falls only after it.
    w_busy_next = (w_state_next != ST_IDLE) || w_pending_next || w_done_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_dropped <= 1'b0;
      r_dtr_out <= 1'b1;
      r_ack     <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_dropped <= w_dropped_next;
      r_dtr_out <= (w_state_next != ST_LOW);
      r_ack     <= w_ack_next;
      r_done    <= w_done_next;
      r_busy    <= w_busy_next;
    end
  end

  assign dtr_out = r_dtr_out;
  assign ack     = r_ack;
  assign busy    = r_busy;
  assign done    = r_done;
  assign dropped = r_dropped;

endmodule
